// File: rtl/soc_trace_monitor.sv
// Snoops a native CPU memory handshake into a show-ahead trace FIFO with per-type event counters.
// Optional address-window filter on bus entries is enabled by defining TRACE_FILTER_EN.
module soc_trace_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic                       mem_ready,
  input  logic                       mem_instr,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  input  logic [3:0]                 mem_wstrb,
  input  logic                       trap,
  input  logic                       cfg_enable,
  input  logic                       cfg_wrap,
  input  logic                       cfg_clear,
`ifdef TRACE_FILTER_EN
  input  logic [31:0]                cfg_lo,
  input  logic [31:0]                cfg_hi,
`endif
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [1:0]                 rd_type,
  output logic [31:0]                rd_addr,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       frozen,
  output logic [CNT_W-1:0]           fetch_cnt,
  output logic [CNT_W-1:0]           load_cnt,
  output logic [CNT_W-1:0]           store_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] TYPE_FETCH = 2'd0;
  localparam logic [1:0] TYPE_LOAD  = 2'd1;
  localparam logic [1:0] TYPE_STORE = 2'd2;
  localparam logic [1:0] TYPE_TRAP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRAP_PEND,
    S_FROZEN
  } state_e;

  state_e           state_q, state_d;
  logic             trapPrev_q;
  logic [31:0]      trapAddr_q, trapAddr_d;
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    level_q;
  logic             overflow_q;
  logic [CNT_W-1:0] fetchCnt_q, loadCnt_q, storeCnt_q;

  logic [65:0]      entryMem [DEPTH];

  logic             evt;
  logic [1:0]       evtType;
  logic [31:0]      evtData;
  logic             trapRise;
  logic             inRange;

  logic             push;
  logic [1:0]       pushType;
  logic [31:0]      pushAddr;
  logic [31:0]      pushData;
  logic             countEn;

  logic             pop;
  logic             full;
  logic             doWrite;
  logic             advRd;
  logic             ovfSet;

  assign evt      = mem_valid && mem_ready;
  assign evtType  = mem_instr ? TYPE_FETCH : ((|mem_wstrb) ? TYPE_STORE : TYPE_LOAD);
  assign evtData  = (evtType == TYPE_STORE) ? mem_wdata : mem_rdata;
  assign trapRise = trap && !trapPrev_q;

`ifdef TRACE_FILTER_EN
  assign inRange = (mem_addr >= cfg_lo) && (mem_addr <= cfg_hi);
`else
  assign inRange = 1'b1;
`endif

  // Capture FSM: a bus event coinciding with a trap edge defers the TRAP entry by one cycle.
  always_comb begin
    state_d    = state_q;
    trapAddr_d = trapAddr_q;
    push       = 1'b0;
    pushType   = evtType;
    pushAddr   = mem_addr;
    pushData   = evtData;
    countEn    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        countEn = evt;
        if (evt && trapRise) begin
          push       = inRange;
          trapAddr_d = mem_addr;
          state_d    = S_TRAP_PEND;
        end else if (trapRise) begin
          push     = 1'b1;
          pushType = TYPE_TRAP;
          pushData = 32'd0;
          state_d  = S_FROZEN;
        end else begin
          push = evt && inRange;
          if (!cfg_enable) state_d = S_IDLE;
        end
      end
      S_TRAP_PEND: begin
        push     = 1'b1;
        pushType = TYPE_TRAP;
        pushAddr = trapAddr_q;
        pushData = 32'd0;
        state_d  = S_FROZEN;
      end
      S_FROZEN: begin
        state_d = S_FROZEN;
      end
      default: state_d = S_IDLE;
    endcase

    if (cfg_clear) begin
      state_d = cfg_enable ? S_ARMED : S_IDLE;
      push    = 1'b0;
      countEn = 1'b0;
    end
  end

  // A pop in the same cycle always makes room, so only a push into a full, non-draining buffer overflows.
  always_comb begin
    pop     = rd_valid && rd_ready;
    full    = (level_q == LW'(DEPTH));
    doWrite = push && (!full || pop || cfg_wrap);
    advRd   = pop || (push && full && !pop && cfg_wrap);
    ovfSet  = push && full && !pop;
  end

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      trapPrev_q <= 1'b0;
      trapAddr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      trapPrev_q <= trap;
      trapAddr_q <= trapAddr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      fetchCnt_q <= '0;
      loadCnt_q  <= '0;
      storeCnt_q <= '0;
    end else if (cfg_clear) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      fetchCnt_q <= '0;
      loadCnt_q  <= '0;
      storeCnt_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + PW'(1);
      if (advRd)   rdPtr_q <= rdPtr_q + PW'(1);
      level_q    <= level_q + LW'(doWrite) - LW'(advRd);
      overflow_q <= overflow_q || ovfSet;
      fetchCnt_q <= satInc(fetchCnt_q, countEn && (evtType == TYPE_FETCH));
      loadCnt_q  <= satInc(loadCnt_q,  countEn && (evtType == TYPE_LOAD));
      storeCnt_q <= satInc(storeCnt_q, countEn && (evtType == TYPE_STORE));
    end
  end

  // Entry storage is plain RAM; validity is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    if (doWrite) entryMem[wrPtr_q] <= {pushType, pushAddr, pushData};
  end

  assign rd_valid  = (level_q != '0);
  assign rd_type   = entryMem[rdPtr_q][65:64];
  assign rd_addr   = entryMem[rdPtr_q][63:32];
  assign rd_data   = entryMem[rdPtr_q][31:0];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign frozen    = (state_q == S_FROZEN);
  assign fetch_cnt = fetchCnt_q;
  assign load_cnt  = loadCnt_q;
  assign store_cnt = storeCnt_q;

endmodule

// File: tb/tb_soc_trace_monitor.sv
// Self-checking bench for soc_trace_monitor: vector table plus scoreboard queue of expected trace entries.
module tb_soc_trace_monitor;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_ready, mem_instr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        trap;
  logic        cfg_enable, cfg_wrap, cfg_clear;
  logic        rd_valid, rd_ready;
  logic [1:0]  rd_type;
  logic [31:0] rd_addr, rd_data;
  logic [$clog2(DEPTH):0] level;
  logic        overflow, frozen;
  logic [CNT_W-1:0] fetch_cnt, load_cnt, store_cnt;

  soc_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wstrb(mem_wstrb),
    .trap(trap), .cfg_enable(cfg_enable), .cfg_wrap(cfg_wrap), .cfg_clear(cfg_clear),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type), .rd_addr(rd_addr), .rd_data(rd_data),
    .level(level), .overflow(overflow), .frozen(frozen),
    .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [1:0]  expType;
    logic [31:0] expData;
  } vec_t;

  entry_t sbQ[$];
  vec_t   vecs[6];
  int     total = 0;
  int     bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [3:0] wstrb);
    mem_valid = 1'b1;
    mem_ready = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_rdata = rdata;
    mem_wstrb = wstrb;
    tick();
    mem_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic expectEntry(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    entry_t e;
    e.t = t; e.a = a; e.d = d;
    sbQ.push_back(e);
  endtask

  task automatic checkHead(input string name);
    entry_t e;
    e = sbQ.pop_front();
    checkOutput({name, ".valid"}, 64'(rd_valid), 64'(1));
    checkOutput({name, ".type"},  64'(rd_type),  64'(e.t));
    checkOutput({name, ".addr"},  64'(rd_addr),  64'(e.a));
    checkOutput({name, ".data"},  64'(rd_data),  64'(e.d));
  endtask

  // Bounded by the scoreboard depth: each iteration consumes one expectation.
  task automatic drainAndCheck(input string name);
    while (sbQ.size() > 0) begin
      rd_ready = 1'b1;
      checkHead(name);
      tick();
    end
    rd_ready = 1'b0;
    checkOutput({name, ".empty"}, 64'(rd_valid), 64'(0));
  endtask

  task automatic pulseClear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expFetch, expLoad, expStore;

    vecs[0] = '{1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 4'hF, 2'd2, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 4'h0, 2'd1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0000_0013, 4'h0, 2'd0, 32'h0000_0013};
    vecs[3] = '{1'b0, 32'h0000_2000, 32'h0000_0055, 32'h0000_0099, 4'h1, 2'd2, 32'h0000_0055};
    vecs[4] = '{1'b0, 32'h0000_3000, 32'h0000_1234, 32'hCAFE_F00D, 4'h0, 2'd1, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_0066, 32'h0000_0077, 4'hF, 2'd0, 32'h0000_0077};

    reset_n = 1'b0; mem_valid = 0; mem_ready = 0; mem_instr = 0;
    mem_addr = 0; mem_wdata = 0; mem_rdata = 0; mem_wstrb = 0; trap = 0;
    cfg_enable = 0; cfg_wrap = 0; cfg_clear = 0; rd_ready = 0;
    tick(); tick();
    checkOutput("reset.rd_valid", 64'(rd_valid), 64'(0));
    checkOutput("reset.level", 64'(level), 64'(0));
    checkOutput("reset.overflow", 64'(overflow), 64'(0));
    checkOutput("reset.frozen", 64'(frozen), 64'(0));
    checkOutput("reset.counters", 64'(fetch_cnt | load_cnt | store_cnt), 64'(0));
    reset_n = 1'b1;
    tick();

    // Idle state must not capture
    applyStimulus(1'b1, 32'h40, 32'h0, 32'h1, 4'h0);
    checkOutput("idle.level", 64'(level), 64'(0));
    checkOutput("idle.fetch_cnt", 64'(fetch_cnt), 64'(0));

    cfg_enable = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h0, 32'h0, 32'h0000_00B7, 4'h0);
    checkOutput("first.rd_valid", 64'(rd_valid), 64'(1));
    checkOutput("first.rd_type", 64'(rd_type), 64'(0));
    checkOutput("first.rd_addr", 64'(rd_addr), 64'(0));
    checkOutput("first.rd_data", 64'(rd_data), 64'h0000_00B7);
    checkOutput("first.fetch_cnt", 64'(fetch_cnt), 64'(1));
    expectEntry(2'd0, 32'h0, 32'h0000_00B7);
    drainAndCheck("first");

    // Handshake without ready is not an event
    mem_valid = 1'b1; mem_ready = 1'b0; mem_instr = 1'b1; mem_addr = 32'h44;
    tick();
    mem_valid = 1'b0;
    checkOutput("noready.level", 64'(level), 64'(0));

    expFetch = 1; expLoad = 0; expStore = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].wstrb);
      expectEntry(vecs[i].expType, vecs[i].addr, vecs[i].expData);
      if (vecs[i].expType == 2'd0) expFetch++;
      if (vecs[i].expType == 2'd1) expLoad++;
      if (vecs[i].expType == 2'd2) expStore++;
    end
    checkOutput("table.level", 64'(level), 64'(6));
    checkOutput("table.fetch_cnt", 64'(fetch_cnt), 64'(expFetch));
    checkOutput("table.load_cnt", 64'(load_cnt), 64'(expLoad));
    checkOutput("table.store_cnt", 64'(store_cnt), 64'(expStore));
    drainAndCheck("table");

    // Full without wrap: newest entries dropped
    pulseClear();
    cfg_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 32'h0, 32'(i), 4'h0);
      if (i < DEPTH) expectEntry(2'd0, 32'(i * 4), 32'(i));
    end
    checkOutput("nowrap.level", 64'(level), 64'(16));
    checkOutput("nowrap.overflow", 64'(overflow), 64'(1));
    checkOutput("nowrap.fetch_cnt", 64'(fetch_cnt), 64'(20));
    drainAndCheck("nowrap");
    checkOutput("nowrap.sticky", 64'(overflow), 64'(1));
    pulseClear();
    checkOutput("clear.overflow", 64'(overflow), 64'(0));
    checkOutput("clear.fetch_cnt", 64'(fetch_cnt), 64'(0));

    // Full with wrap: oldest entries overwritten
    cfg_wrap = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 32'h0, 32'(i + 100), 4'h0);
      if (i >= 20 - DEPTH) expectEntry(2'd0, 32'(i * 4), 32'(i + 100));
    end
    checkOutput("wrap.level", 64'(level), 64'(16));
    checkOutput("wrap.overflow", 64'(overflow), 64'(1));
    drainAndCheck("wrap");
    pulseClear();

    // Full, no wrap, push with simultaneous pop: no drop, no overflow
    cfg_wrap = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i * 4), 32'h0, 32'(i), 4'h0);
      expectEntry(2'd0, 32'h100 + 32'(i * 4), 32'(i));
    end
    checkOutput("pushpop.full", 64'(overflow), 64'(0));
    rd_ready = 1'b1;
    checkHead("pushpop.head");
    applyStimulus(1'b1, 32'h200, 32'h0, 32'h5A5A, 4'h0);
    rd_ready = 1'b0;
    expectEntry(2'd0, 32'h200, 32'h5A5A);
    checkOutput("pushpop.level", 64'(level), 64'(16));
    checkOutput("pushpop.overflow", 64'(overflow), 64'(0));
    drainAndCheck("pushpop");
    pulseClear();

    // Event and trap rise together: FETCH now, TRAP next cycle, then frozen
    trap = 1'b1;
    applyStimulus(1'b1, 32'h20, 32'h0, 32'h1234_5678, 4'h0);
    checkOutput("trap.level1", 64'(level), 64'(1));
    checkOutput("trap.notyet", 64'(frozen), 64'(0));
    applyStimulus(1'b1, 32'h24, 32'h0, 32'h1, 4'h0);
    checkOutput("trap.level2", 64'(level), 64'(2));
    checkOutput("trap.frozen", 64'(frozen), 64'(1));
    trap = 1'b0;
    applyStimulus(1'b0, 32'h28, 32'h0, 32'h2, 4'h0);
    checkOutput("trap.ignored", 64'(level), 64'(2));
    checkOutput("trap.fetch_cnt", 64'(fetch_cnt), 64'(1));
    checkOutput("trap.load_cnt", 64'(load_cnt), 64'(0));
    expectEntry(2'd0, 32'h20, 32'h1234_5678);
    expectEntry(2'd3, 32'h20, 32'h0);
    drainAndCheck("trap");
    pulseClear();
    checkOutput("trapclr.frozen", 64'(frozen), 64'(0));
    checkOutput("trapclr.counters", 64'(fetch_cnt | load_cnt | store_cnt), 64'(0));

    // Trap rise alone: TRAP entry written immediately
    mem_addr = 32'h300;
    trap = 1'b1;
    tick();
    trap = 1'b0;
    checkOutput("trap2.frozen", 64'(frozen), 64'(1));
    expectEntry(2'd3, 32'h300, 32'h0);
    drainAndCheck("trap2");
    pulseClear();

    // Asynchronous reset in the middle of a pop
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h500 + 32'(i * 4), 32'h0, 32'(i), 4'h0);
    checkOutput("midpop.level", 64'(level), 64'(5));
    rd_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midpop.rd_valid", 64'(rd_valid), 64'(0));
    checkOutput("midpop.level0", 64'(level), 64'(0));
    checkOutput("midpop.load_cnt", 64'(load_cnt), 64'(0));
    rd_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
